pdm_decimator: RTL and testbench

PDM_DECIMATOR -- requirements
Module: pdm_decimator

---
 rtl/synth_pkg.sv | 12 +
 rtl/cic_comb.sv | 26 ++
 rtl/pdm_decimator.sv | 92 +++++++++
 tb/tb_pdm_decimator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants for the PDM decimator
package synth_pkg;

  localparam int DECIM_LOG2_DEFAULT = 9;
  localparam int PCM_W = 16;

  // A 2nd-order CIC grows by 2*log2(R) bits over a 1-bit input, plus one sign bit.
  function automatic int cic_acc_width(input int decim_log2);
    return 2 * decim_log2 + 1;
  endfunction

endpackage

// File: rtl/cic_comb.sv
// rtl/cic_comb.sv - single CIC comb stage, differential delay 1
module cic_comb
  import synth_pkg::*;
#(
  parameter int ACC_W = cic_acc_width(DECIM_LOG2_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] y
);

  logic [ACC_W-1:0] dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      dly <= '0;
    end else if (en) begin
      dly <= x;
    end
  end

  assign y = x - dly;

endmodule

// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - 2nd-order CIC decimator, 1-bit PDM in, 16-bit PCM out
module pdm_decimator
  import synth_pkg::*;
#(
  parameter int DECIM_LOG2 = DECIM_LOG2_DEFAULT,
  parameter int ACC_W      = cic_acc_width(DECIM_LOG2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [PCM_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);

  localparam int SHIFT = 2 * DECIM_LOG2 - PCM_W;
  localparam logic [ACC_W-1:0] PCM_MAX = ACC_W'((1 << PCM_W) - 1);

  logic [ACC_W-1:0]      int1;
  logic [ACC_W-1:0]      int2;
  logic [ACC_W-1:0]      c1;
  logic [ACC_W-1:0]      y;
  logic [ACC_W-1:0]      y_sh;
  logic [PCM_W-1:0]      pcm;
  logic [DECIM_LOG2-1:0] cnt;
  logic [1:0]            settle;
  logic                  strobe;
  logic                  settled;

  assign strobe  = (cnt == {DECIM_LOG2{1'b1}});
  assign settled = (settle == 2'd2);

  // Integrators wrap modulo 2^ACC_W; the combs undo the wrap exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      int1 <= '0;
      int2 <= '0;
      cnt  <= '0;
    end else begin
      int1 <= int1 + ACC_W'(din);
      int2 <= int2 + int1;
      cnt  <= cnt + 1'b1;
    end
  end

  cic_comb #(.ACC_W(ACC_W)) u_comb1 (
    .clk (clk),
    .rst (rst),
    .en  (strobe),
    .x   (int2),
    .y   (c1)
  );

  cic_comb #(.ACC_W(ACC_W)) u_comb2 (
    .clk (clk),
    .rst (rst),
    .en  (strobe),
    .x   (c1),
    .y   (y)
  );

  // Full-scale ones give exactly 2^16 after the shift, so clamp to 16 bits.
  assign y_sh = y >> SHIFT;
  assign pcm  = (y_sh > PCM_MAX) ? PCM_MAX[PCM_W-1:0] : y_sh[PCM_W-1:0];

  // The first two strobes only prime the comb delays.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle <= 2'd0;
    end else if (strobe && !settled) begin
      settle <= settle + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (strobe && settled) begin
      dout       <= pcm;
      dout_valid <= 1'b1;
      if (dout_valid && !dout_ready) begin
        overrun <= 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb/tb_pdm_decimator.sv - self-checking bench for pdm_decimator
module tb_pdm_decimator;
  import synth_pkg::*;

  typedef struct {
    int val;
    int at;
    int tol;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        dout_ready = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        overrun;

  int          rel = 0;
  int          checks = 0;
  int          errors = 0;
  int          pat = 0;
  logic [15:0] sd_acc = '0;
  exp_t        sb[$];

  pdm_decimator dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Edges since the last cycle with rst high.
  always @(posedge clk) rel <= rst ? 0 : rel + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp_v, input int tol);
    checks++;
    assert ((obs >= exp_v - tol) && (obs <= exp_v + tol)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp_v, tol);
    end
  endtask

  // Pattern 3 models a first-order sigma-delta DAC fed a constant 0x4000.
  task automatic drive_din();
    case (pat)
      0:       din = 1'b0;
      1:       din = 1'b1;
      2:       din = ~rel[0];
      default: {din, sd_acc} = {1'b0, sd_acc} + 17'h04000;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    drive_din();
  endtask

  task automatic do_reset(input int p);
    @(negedge clk);
    rst = 1'b1;
    dout_ready = 1'b0;
    pat = p;
    sd_acc = '0;
    din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    dout_ready = 1'b1;
    drive_din();
  endtask

  task automatic push_n(input int val, input int n, input int tol);
    for (int k = 0; k < n; k++) sb.push_back('{val, 1536 + 512 * k, tol});
  endtask

  task automatic drain(input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
      if (dout_valid && dout_ready) begin
        e = sb.pop_front();
        check_near("dout", int'(dout), e.val, e.tol);
        check("valid_at", rel, e.at);
      end
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    int   n;
    exp_t e;

    do_reset(1);
    push_n(65535, 4, 0);
    drain(4000);

    do_reset(0);
    push_n(0, 3, 0);
    drain(4000);

    do_reset(2);
    push_n(32768, 3, 0);
    drain(4000);

    do_reset(3);
    push_n(16384, 3, 64);
    drain(4000);

    // Overrun: hold off the consumer across two overwrites, input goes silent.
    do_reset(1);
    n = 0;
    while (!dout_valid && n < 4000) begin
      step();
      n++;
    end
    check("ovr_first_at", rel, 1536);
    check("ovr_first_dout", dout, 65535);
    dout_ready = 1'b0;
    pat = 0;
    drive_din();
    sb.push_back('{0, 2636, 0});
    while (rel < 2636 && n < 4000) begin
      step();
      n++;
      if (rel == 2047) begin
        check("ovr_hold_dout", dout, 65535);
        check("ovr_before", overrun, 0);
      end
      if (rel == 2048) begin
        check("ovr_set", overrun, 1);
        check("ovr_valid_held", dout_valid, 1);
      end
    end
    e = sb.pop_front();
    check("ovr_at", rel, e.at);
    check("ovr_valid", dout_valid, 1);
    check("ovr_latest", dout, e.val);
    check("ovr_sticky", overrun, 1);
    dout_ready = 1'b1;
    step();
    check("ovr_valid_drop", dout_valid, 0);
    check("ovr_still_set", overrun, 1);

    // Mid-stream reset abandons a pending sample and restarts settling.
    do_reset(1);
    dout_ready = 1'b0;
    n = 0;
    while (rel < 2000 && n < 4000) begin
      step();
      n++;
    end
    check("rp_pending", dout_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rp_dout", dout, 0);
    check("rp_valid", dout_valid, 0);
    check("rp_overrun", overrun, 0);
    rst = 1'b0;
    dout_ready = 1'b1;
    drive_din();
    push_n(65535, 1, 0);
    drain(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
